// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
interface fetch_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req_o;
    logic [DATA_WIDTH-1:0] imem_addr_o;
    logic                  imem_gnt_i;
    logic                  imem_rvalid_i;
    logic [DATA_WIDTH-1:0] imem_rdata_i;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i
    );
endinterface

// File: rtl/fetch_unit.sv
// Pipeline front end: owns the PC, fetches over req/gnt/rvalid, buffers
// returned words with their PC, and squashes stale work on an execute redirect.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StallF_i,
    input  logic                  branchTaken_i,
    input  logic [DATA_WIDTH-1:0] PCTargetE_i,
    fetch_unit_if.master          imem,
    output logic [DATA_WIDTH-1:0] InstrD_o,
    output logic [DATA_WIDTH-1:0] PCD_o,
    output logic [DATA_WIDTH-1:0] PCPlus4D_o,
    output logic                  ValidD_o,
    output logic                  FlushD_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]           DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP     = DATA_WIDTH'(32'h0000_0013);
    localparam logic [DATA_WIDTH-1:0] FOUR    = DATA_WIDTH'(4);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]         out_q, out_d;
    logic [CW-1:0]         disc_q, disc_d;
    logic [CW-1:0]         buf_cnt_q, buf_cnt_d;
    logic [AW-1:0]         pcq_rd_q, pcq_wr_q, buf_rd_q, buf_wr_q;
    logic [DATA_WIDTH-1:0] last_pc_q;

    logic [DATA_WIDTH-1:0] pcq_mem_q   [DEPTH];
    logic [DATA_WIDTH-1:0] buf_instr_q [DEPTH];
    logic [DATA_WIDTH-1:0] buf_pc_q    [DEPTH];

    logic          redirect, req, hs, rsp, push, pop;
    logic [CW:0]   occ;

    // Low target bits are forced to word alignment and never used.
    logic unused_tgt_lsbs;
    assign unused_tgt_lsbs = ^PCTargetE_i[1:0];

    assign redirect = branchTaken_i && (state_q != IDLE);
    assign occ      = {1'b0, out_q} + {1'b0, buf_cnt_q};
    assign req      = (state_q == FETCH) && (occ < DEPTH_C) && !branchTaken_i;
    assign hs       = req && imem.imem_gnt_i;
    assign rsp      = imem.imem_rvalid_i && (out_q != '0);
    // A response in the redirect cycle belongs to the squashed path.
    assign push     = rsp && (disc_q == '0) && !redirect;
    assign pop      = ValidD_o && !StallF_i && !redirect;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        disc_d    = disc_q;
        out_d     = out_q + CW'(hs) - CW'(rsp);
        buf_cnt_d = buf_cnt_q + CW'(push) - CW'(pop);
        if (redirect) begin
            pc_d      = {PCTargetE_i[DATA_WIDTH-1:2], 2'b00};
            disc_d    = out_q - CW'(rsp);
            buf_cnt_d = '0;
        end else begin
            if (hs)
                pc_d = pc_q + FOUR;
            if (rsp && (disc_q != '0))
                disc_d = disc_q - CW'(1);
        end
        unique case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (redirect && (disc_d != '0)) state_d = DRAIN;
            DRAIN:   if (disc_d == '0) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            out_q     <= '0;
            disc_q    <= '0;
            buf_cnt_q <= '0;
            pcq_rd_q  <= '0;
            pcq_wr_q  <= '0;
            buf_rd_q  <= '0;
            buf_wr_q  <= '0;
            last_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            out_q     <= out_d;
            disc_q    <= disc_d;
            buf_cnt_q <= buf_cnt_d;
            if (ValidD_o)
                last_pc_q <= buf_pc_q[buf_rd_q];
            if (redirect) begin
                pcq_rd_q <= '0;
                pcq_wr_q <= '0;
                buf_rd_q <= '0;
                buf_wr_q <= '0;
            end else begin
                if (hs)   pcq_wr_q <= pcq_wr_q + AW'(1);
                if (push) pcq_rd_q <= pcq_rd_q + AW'(1);
                if (push) buf_wr_q <= buf_wr_q + AW'(1);
                if (pop)  buf_rd_q <= buf_rd_q + AW'(1);
            end
        end
    end

    // Storage arrays need no reset; pointers and counts qualify them.
    always_ff @(posedge clk) begin
        if (!rst && hs)
            pcq_mem_q[pcq_wr_q] <= pc_q;
        if (!rst && push) begin
            buf_instr_q[buf_wr_q] <= imem.imem_rdata_i;
            buf_pc_q[buf_wr_q]    <= pcq_mem_q[pcq_rd_q];
        end
    end

    assign imem.imem_req_o  = req;
    assign imem.imem_addr_o = pc_q;

    assign ValidD_o   = (buf_cnt_q != '0);
    assign InstrD_o   = ValidD_o ? buf_instr_q[buf_rd_q] : NOP;
    assign PCD_o      = ValidD_o ? buf_pc_q[buf_rd_q] : last_pc_q;
    assign PCPlus4D_o = PCD_o + FOUR;
    assign FlushD_o   = branchTaken_i && !rst;
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based model of the
// in-flight requests and the decode-side instruction stream.
module tb_fetch_unit;
    localparam int          DW       = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_A5A5;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic          StallF, bt;
    logic [DW-1:0] tgt;
    logic [DW-1:0] InstrD, PCD, PCPlus4D;
    logic          ValidD, FlushD;

    always #5 clk = ~clk;

    fetch_unit_if #(.DATA_WIDTH(DW)) imem ();

    fetch_unit #(.DATA_WIDTH(DW), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .StallF_i     (StallF),
        .branchTaken_i(bt),
        .PCTargetE_i  (tgt),
        .imem         (imem),
        .InstrD_o     (InstrD),
        .PCD_o        (PCD),
        .PCPlus4D_o   (PCPlus4D),
        .ValidD_o     (ValidD),
        .FlushD_o     (FlushD)
    );

    typedef struct {
        logic [31:0] maddr;
        logic [31:0] pc;
        bit          stale;
    } pend_t;

    pend_t       pend[$];   // granted requests not yet answered by memory
    logic [31:0] bufq[$];   // PCs expected at decode, oldest first
    logic [31:0] exp_pc;
    logic [31:0] last_pcd;
    bit          idle;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int n_stale();
        int n = 0;
        foreach (pend[i]) if (pend[i].stale) n++;
        return n;
    endfunction

    // One clock cycle, entered and left at a falling edge. rv: 0 none,
    // 1 respond if something is pending, 2 pulse rvalid regardless.
    task automatic step(input bit st, input bit b, input logic [31:0] t, input bit g, input int rv);
        bit          valid_e, be, req_e, hs, rv_now, do_pop, have_push;
        logic [31:0] addr_now, push_pc;
        pend_t       e;
        valid_e = bufq.size() > 0;
        if (valid_e) last_pcd = bufq[0];
        chk("ValidD", 32'(ValidD), 32'(valid_e));
        chk("PCD", PCD, last_pcd);
        chk("InstrD", InstrD, valid_e ? (bufq[0] ^ KEY) : NOP);
        chk("PCPlus4D", PCPlus4D, last_pcd + 32'd4);

        StallF = st; bt = b; tgt = t;
        imem.imem_gnt_i    = g;
        imem.imem_rvalid_i = (rv == 2) || (rv == 1 && pend.size() > 0);
        imem.imem_rdata_i  = (pend.size() > 0) ? (pend[0].maddr ^ KEY) : 32'hDEAD_BEEF;
        #1;
        be    = b && !idle;
        req_e = !idle && (n_stale() == 0) && (pend.size() + bufq.size() < DEPTH) && !b;
        chk("req", 32'(imem.imem_req_o), 32'(req_e));
        chk("addr", imem.imem_addr_o, exp_pc);
        chk("FlushD", 32'(FlushD), 32'(b));
        hs       = imem.imem_req_o && g;
        addr_now = imem.imem_addr_o;
        rv_now   = imem.imem_rvalid_i;
        @(posedge clk);

        do_pop    = (bufq.size() > 0) && !st && !be;
        have_push = 1'b0;
        push_pc   = '0;
        if (rv_now && pend.size() > 0) begin
            e = pend.pop_front();
            if (!e.stale && !be) begin
                have_push = 1'b1;
                push_pc   = e.pc;
            end
        end
        if (do_pop) void'(bufq.pop_front());
        if (be) begin
            bufq.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
        end else if (have_push) begin
            bufq.push_back(push_pc);
        end
        if (hs) begin
            pend.push_back('{maddr: addr_now, pc: exp_pc, stale: be});
            if (!be) exp_pc = exp_pc + 32'd4;
        end
        if (be) exp_pc = {t[31:2], 2'b00};
        idle = 1'b0;
        @(negedge clk);
    endtask

    // Reset held for n cycles with redirect and rvalid asserted to show
    // that reset overrides them.
    task automatic do_reset(input int n);
        rst = 1'b1; bt = 1'b1; tgt = 32'h40; StallF = 1'b0;
        imem.imem_gnt_i = 1'b1; imem.imem_rvalid_i = 1'b1; imem.imem_rdata_i = 32'hDEAD_BEEF;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_ValidD", 32'(ValidD), 32'd0);
            chk("rst_InstrD", InstrD, NOP);
            chk("rst_PCD", PCD, 32'd0);
            chk("rst_PCPlus4D", PCPlus4D, 32'd4);
            chk("rst_req", 32'(imem.imem_req_o), 32'd0);
            chk("rst_addr", imem.imem_addr_o, RESET_PC);
            chk("rst_FlushD", 32'(FlushD), 32'd0);
        end
        pend.delete();
        bufq.delete();
        exp_pc   = RESET_PC;
        last_pcd = '0;
        idle     = 1'b1;
        rst = 1'b0; bt = 1'b0;
        imem.imem_rvalid_i = 1'b0;
    endtask

    initial begin
        bit          st, b, g;
        int          rv;
        logic [31:0] t;

        do_reset(2);

        // Free-running memory: first word visible at cycle 3.
        for (int c = 0; c < 12; c++) begin
            if (c == 3) begin
                chk("lat_ValidD", 32'(ValidD), 32'd1);
                chk("lat_PCD", PCD, RESET_PC);
                chk("lat_InstrD", InstrD, RESET_PC ^ KEY);
            end
            step(1'b0, 1'b0, '0, 1'b1, 1);
        end

        repeat (5) step(1'b1, 1'b0, '0, 1'b1, 1);
        chk("stall_ValidD", 32'(ValidD), 32'd1);
        repeat (6) step(1'b0, 1'b0, '0, 1'b1, 1);

        // Two outstanding, then redirect to 0x103.
        repeat (3) step(1'b0, 1'b0, '0, 1'b1, 0);
        step(1'b0, 1'b1, 32'h103, 1'b1, 0);
        chk("redir_ValidD", 32'(ValidD), 32'd0);
        repeat (8) step(1'b0, 1'b0, '0, 1'b1, 1);

        // Redirect coinciding with a response.
        repeat (3) step(1'b0, 1'b0, '0, 1'b1, 0);
        step(1'b0, 1'b1, 32'h300, 1'b1, 1);
        repeat (6) step(1'b0, 1'b0, '0, 1'b1, 1);

        // Second redirect while draining.
        repeat (3) step(1'b0, 1'b0, '0, 1'b1, 0);
        step(1'b0, 1'b1, 32'h180, 1'b1, 0);
        step(1'b0, 1'b1, 32'h200, 1'b1, 1);
        repeat (6) step(1'b0, 1'b0, '0, 1'b1, 1);

        // Grant withheld: address must hold.
        repeat (3) step(1'b0, 1'b0, '0, 1'b0, 1);
        repeat (4) step(1'b0, 1'b0, '0, 1'b1, 1);

        // Address wrap at the top of the space.
        step(1'b0, 1'b1, 32'hFFFF_FFF9, 1'b1, 1);
        repeat (8) step(1'b0, 1'b0, '0, 1'b1, 1);

        // Reset mid-stream with requests in flight, then late rvalid pulses.
        repeat (3) step(1'b0, 1'b0, '0, 1'b1, 0);
        do_reset(1);
        step(1'b0, 1'b0, '0, 1'b1, 2);
        step(1'b0, 1'b0, '0, 1'b1, 2);
        repeat (6) step(1'b0, 1'b0, '0, 1'b1, 1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499) == 0) begin
                do_reset(1);
                continue;
            end
            st = ($urandom_range(3) == 0);
            g  = ($urandom_range(3) != 0);
            rv = ($urandom_range(2) != 0) ? 1 : 0;
            b  = ($urandom_range(15) == 0);
            t  = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            step(st, b, t, g, rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front end of the pipeline. Owns the PC, issues instruction-memory requests over a req/gnt/rvalid handshake, buffers returned instructions with their PC, and presents them to decode.
- Consumes the branch/jump redirect (branch-taken flag plus target PC) produced by the execute stage, and squashes all younger work.
- Receives that redirect rather than generating it.

Parameters:
- DATA_WIDTH, 32, width of PC, address and instruction.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, maximum outstanding requests plus buffered instructions (power of 2, ≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- StallF_i  in  1  decode cannot accept an instruction this cycle.
- branchTaken_i  in  1  redirect request from execute.
- PCTargetE_i  in  DATA_WIDTH  redirect target from execute.
- imem_req_o  out  1  request valid.
- imem_addr_o  out  DATA_WIDTH  request address (current PC).
- imem_gnt_i  in  1  memory accepts the request this cycle.
- imem_rvalid_i  in  1  response data valid; responses arrive in order, ≥1 cycle after grant.
- imem_rdata_i  in  DATA_WIDTH  response instruction word.
- InstrD_o  out  DATA_WIDTH  instruction at buffer head.
- PCD_o  out  DATA_WIDTH  PC of InstrD_o.
- PCPlus4D_o  out  DATA_WIDTH  PCD_o + 4.
- ValidD_o  out  1  InstrD_o/PCD_o valid.
- FlushD_o  out  1  squash decode pipeline register.

Behaviour:
- Reset: state=IDLE, PC=RESET_PC, outstanding=0, discard=0, buffer empty. imem_req_o=0, imem_addr_o=RESET_PC, ValidD_o=0, InstrD_o=32'h0000_0013, PCD_o=0, PCPlus4D_o=4, FlushD_o=0. Reset overrides every other input.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE→FETCH unconditionally on the next cycle.
  - FETCH→DRAIN on redirect when stale in-flight responses remain, else stay in FETCH.
  - DRAIN→FETCH when discard reaches 0 (same edge as the last stale rvalid).
- Issue:
  - imem_req_o = (state==FETCH) && (outstanding + occupancy < DEPTH) && !branchTaken_i.
  - A handshake occurs when imem_req_o && imem_gnt_i: PC += 4 and outstanding increments. The PC is held stable while a request is ungranted.
- Response:
  - rvalid with discard>0: word dropped, discard decrements, outstanding decrements.
  - rvalid with discard==0 and outstanding>0: {rdata, PC-of-request} pushed to the buffer, outstanding decrements.
  - rvalid with outstanding==0: ignored.
  - Request PCs are tracked in a DEPTH-entry in-order PC queue.
- Output:
  - ValidD_o = buffer non-empty; head is presented combinationally.
  - Pop occurs when ValidD_o && !StallF_i.
  - When empty, InstrD_o=32'h0000_0013 (NOP) and PCD_o holds its last value.
  - Push and pop in the same cycle are allowed. The buffer never overflows by construction of the issue rule.
- Redirect (branchTaken_i=1, any state except IDLE):
  - PC ← {PCTargetE_i[DATA_WIDTH-1:2], 2'b00}.
  - Buffer and PC queue cleared.
  - discard ← outstanding − (rvalid this cycle ? 1 : 0); a response arriving in the redirect cycle is itself dropped.
  - No request is issued in the redirect cycle.
- FlushD_o = branchTaken_i && !rst (combinational).
- Precedence: rst > redirect > StallF_i. A redirect while stalled still clears the buffer.
- Redirect while in DRAIN: PC updated, discard recomputed per the rule above, remain in DRAIN.
- Address arithmetic wraps modulo 2^DATA_WIDTH (0xFFFF_FFFC + 4 = 0).

Test Plan:
- Reset then free-running memory (gnt=1, rvalid 1 cycle later, rdata=addr^0xA5A5A5A5): first req at cycle 1 with addr RESET_PC; ValidD_o at cycle 3 with PCD_o=0, InstrD_o=0xA5A5A5A5; then one instruction per cycle at PCs 4, 8, 12.
- StallF_i held for 5 cycles: buffer fills to DEPTH, imem_req_o drops to 0, PCD_o holds. On release, the sequence continues with no gap or duplicate PC.
- branchTaken_i with PCTargetE_i=0x103 while 2 requests are outstanding: FlushD_o=1 that cycle, ValidD_o=0 next cycle, both stale responses dropped, next delivered PCD_o=0x100.
- Redirect on the same cycle as an rvalid: that word is dropped, discard equals outstanding−1, no stale PC reaches decode.
- A second redirect (target 0x200) during DRAIN: only instructions from 0x200 onward are delivered. gnt withheld 3 cycles: imem_addr_o stable, PC not advanced.
- Reset asserted mid-stream with 2 outstanding: outputs return to reset values next cycle; late rvalid pulses are ignored; fetch restarts at RESET_PC.
